// File: rtl/stimulus_sequencer.sv
// stimulus_sequencer
//   Stimulus source for DE10-Lite lab designs. A start pulse holds the DUT
//   reset for reset_cycles clocks. The block then applies num_vectors
//   key/switch vectors, each held for hold_cycles clocks, taken from one of
//   four pattern generators (random LFSR, walking one, counter, all-zero).
//   When the last vector completes it reports done.
//
// Ports
//   clk          system clock
//   reset        synchronous active-high reset
//   start        one-clock pulse; begins a run when idle or done
//   mode         pattern select, latched at start (0 rnd, 1 walk, 2 cnt, 3 zero)
//   key          key stimulus       (low part of V = {sw,key})
//   sw           switch stimulus    (high part of V = {sw,key})
//   dut_reset    reset driven to the DUT (high in IDLE and RESET_DUT)
//   busy         high in RESET_DUT and RUN
//   done         high in DONE
//   vector_count vectors completed in the current or last run

module stimulus_sequencer #(
  parameter int unsigned key_width    = 2,
  parameter int unsigned sw_width     = 9,
  parameter int unsigned reset_cycles = 2,
  parameter int unsigned num_vectors  = 1000,
  parameter int unsigned hold_cycles  = 1,
  parameter logic [31:0] lfsr_seed    = 32'h1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [1:0]                         mode,
  output logic [key_width-1:0]               key,
  output logic [sw_width-1:0]                sw,
  output logic                               dut_reset,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(num_vectors+1)-1:0]   vector_count
);

  localparam int unsigned W    = sw_width + key_width;
  localparam int unsigned VCW  = $clog2(num_vectors + 1);
  localparam int unsigned RC   = (reset_cycles < 1) ? 1 : reset_cycles;
  localparam int unsigned RCW  = (RC > 1) ? $clog2(RC) : 1;
  localparam int unsigned HCW  = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  localparam int unsigned WPW  = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned REPS = (W + 31) / 32;
  localparam logic [31:0] SEED = (lfsr_seed == 32'h0) ? 32'h1 : lfsr_seed;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESET_DUT = 2'd1,
    RUN       = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [RCW-1:0]     rst_cnt_q;
  logic [HCW-1:0]     hold_cnt_q;
  logic [VCW-1:0]     vcount_q;
  logic [31:0]        lfsr_q;
  logic [1:0]         mode_q;
  logic [W-1:0]       vec_q;
  logic [W-1:0]       idx_q;
  logic [WPW-1:0]     wpos_q;

  logic               start_ok;
  logic               rst_last;
  logic               hold_last;
  logic               last_vec;
  logic               first_load;
  logic               next_load;
  logic [W-1:0]       load_idx;
  logic [WPW-1:0]     load_wpos;
  logic [31:0]        lfsr_shift;
  logic [32*REPS-1:0] lfsr_rep;
  logic [W-1:0]       load_vec;

  // Datapath control and next-vector generation
  always_comb begin
    start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
    rst_last   = (rst_cnt_q == RCW'(RC - 1));
    hold_last  = (hold_cnt_q == HCW'(hold_cycles - 1));
    last_vec   = (vcount_q == VCW'(num_vectors - 1));
    first_load = (state_q == RESET_DUT) && rst_last;
    next_load  = (state_q == RUN) && hold_last && !last_vec;

    load_idx   = first_load ? '0 : idx_q + 1'b1;
    if (first_load || (wpos_q == WPW'(W - 1)))
      load_wpos = '0;
    else
      load_wpos = wpos_q + 1'b1;

    // Galois step; the vector shows the state after the shift
    lfsr_shift = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    // Widths above 32 reuse state bits modulo 32
    lfsr_rep   = {REPS{lfsr_shift}};

    case (mode_q)
      2'd0:    load_vec = lfsr_rep[W-1:0];
      2'd1:    load_vec = W'(1) << load_wpos;
      2'd2:    load_vec = load_idx;
      default: load_vec = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = RESET_DUT;
      RESET_DUT: if (rst_last) state_d = RUN;
      RUN:       if (hold_last && last_vec) state_d = DONE;
      DONE:      if (start) state_d = RESET_DUT;
      default:   state_d = IDLE;
    endcase
  end

  // Counters, pattern state and vector register
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt_q  <= '0;
      hold_cnt_q <= '0;
      vcount_q   <= '0;
      lfsr_q     <= SEED;
      mode_q     <= '0;
      vec_q      <= '0;
      idx_q      <= '0;
      wpos_q     <= '0;
    end else begin
      if (start_ok) begin
        mode_q    <= mode;
        rst_cnt_q <= '0;
        vcount_q  <= '0;
      end
      if (state_q == RESET_DUT)
        rst_cnt_q <= rst_cnt_q + 1'b1;
      if (first_load || next_load) begin
        vec_q      <= load_vec;
        idx_q      <= load_idx;
        wpos_q     <= load_wpos;
        hold_cnt_q <= '0;
        if (mode_q == 2'd0)
          lfsr_q <= lfsr_shift;
      end else if (state_q == RUN) begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
      if ((state_q == RUN) && hold_last)
        vcount_q <= vcount_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    busy         = (state_q == RESET_DUT) || (state_q == RUN);
    done         = (state_q == DONE);
    dut_reset    = (state_q == IDLE) || (state_q == RESET_DUT);
    key          = '0;
    sw           = '0;
    if (state_q == RUN) begin
      key = vec_q[key_width-1:0];
      sw  = vec_q[W-1:key_width];
    end
    vector_count = vcount_q;
  end

endmodule

// File: tb/tb_stimulus_sequencer.sv
// tb_stimulus_sequencer
//   Scoreboard bench: each run pushes the expected {sw,key}/vector_count
//   stream into a queue, and a monitor pops and compares it on every RUN
//   clock. Covers reset state, start latency, all four modes, walking-one
//   wrap, vector hold, ignored start, restart from DONE, mid-run reset and
//   simultaneous start/reset.

module tb_stimulus_sequencer;

  localparam int unsigned KW   = 2;
  localparam int unsigned SW   = 9;
  localparam int unsigned W    = KW + SW;
  localparam int unsigned RC   = 2;
  localparam int unsigned NV   = 12;
  localparam int unsigned HC   = 2;
  localparam int unsigned VCW  = $clog2(NV + 1);
  localparam logic [31:0] SEED = 32'h1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [KW-1:0]  key;
  logic [SW-1:0]  sw;
  logic           dut_reset;
  logic           busy;
  logic           done;
  logic [VCW-1:0] vector_count;

  always #5 clk = ~clk;

  stimulus_sequencer #(
    .key_width   (KW),
    .sw_width    (SW),
    .reset_cycles(RC),
    .num_vectors (NV),
    .hold_cycles (HC),
    .lfsr_seed   (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .key         (key),
    .sw          (sw),
    .dut_reset   (dut_reset),
    .busy        (busy),
    .done        (done),
    .vector_count(vector_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] v;
    logic [31:0]  c;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_lfsr = SEED;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Expected stream for one complete run
  task automatic push_run(input logic [1:0] m);
    logic [W-1:0] one;
    logic [W-1:0] val;
    exp_t         e;
    one = 1;
    for (int v = 0; v < int'(NV); v++) begin
      case (m)
        2'd0: begin
          m_lfsr = m_step(m_lfsr);
          val    = m_lfsr[W-1:0];
        end
        2'd1:    val = one << (v % int'(W));
        2'd2:    val = W'(v);
        default: val = '0;
      endcase
      e.v = val;
      e.c = 32'(v);
      for (int h = 0; h < int'(HC); h++) exp_q.push_back(e);
    end
  endtask

  // Monitor: every RUN clock consumes one expected entry
  always @(negedge clk) begin
    exp_t e;
    if (busy && !dut_reset) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("vec", 32'({sw, key}), 32'(e.v));
        check("vcount", 32'(vector_count), e.c);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic do_run(input logic [1:0] m, input bit poke);
    push_run(m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = ~m;
    @(negedge clk);
    check("busy_rst", 32'(busy), 32'd1);
    check("dutrst_1", 32'(dut_reset), 32'd1);
    check("vc_clear", 32'(vector_count), 32'd0);
    check("key_rstdut", 32'(key), 32'd0);
    check("sw_rstdut", 32'(sw), 32'd0);
    check("done_clr", 32'(done), 32'd0);
    @(negedge clk);
    check("dutrst_2", 32'(dut_reset), 32'd1);
    @(negedge clk);
    check("dutrst_fall", 32'(dut_reset), 32'd0);
    check("busy_run", 32'(busy), 32'd1);
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    check("vc_final", 32'(vector_count), NV);
    check("key_done", 32'(key), 32'd0);
    check("sw_done", 32'(sw), 32'd0);
    check("dutrst_done", 32'(dut_reset), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key", 32'(key), 32'd0);
    check("rst_sw", 32'(sw), 32'd0);
    check("rst_dutrst", 32'(dut_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_vc", 32'(vector_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_run(2'd2, 1'b0);   // counter
    do_run(2'd1, 1'b1);   // walking one, restart from DONE, ignored start
    do_run(2'd0, 1'b1);   // random from seed
    do_run(2'd0, 1'b0);   // random continues, no reseed
    do_run(2'd3, 1'b0);   // all-zero

    // Reset in the middle of a counter run
    push_run(2'd2);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (vector_count != VCW'(5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("vc_reach5", 32'(vector_count), 32'd5);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_lfsr = SEED;
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_dutrst", 32'(dut_reset), 32'd1);
    check("mid_key", 32'(key), 32'd0);
    check("mid_sw", 32'(sw), 32'd0);
    check("mid_vc", 32'(vector_count), 32'd0);

    // Start and reset on the same edge: reset wins
    @(posedge clk); #1;
    start = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("sr_busy", 32'(busy), 32'd0);
    check("sr_dutrst", 32'(dut_reset), 32'd1);
    @(negedge clk);
    check("sr_busy2", 32'(busy), 32'd0);

    // LFSR reloaded by reset: random run starts again from the seed
    do_run(2'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
